mul_pair_engine: RTL

- Memory-walking signed-multiply engine; the DUT-side stage that consumes the operand block the program-3 harness loads into data memory and produces the product block it checks.
- Reads 16 pairs of 16-bit two's-complement operands from byte-wide data memory and multiplies each pair with an internal radix-2 Booth sequencer.
- Writes each 32-bit product back big-endian, then raises done.

---
 rtl/mul_pair_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mul_pair_engine.sv
// Walks NUM_PAIRS signed 16-bit operand pairs in byte memory and writes each
// 32-bit product back big-endian, using a 16-cycle radix-2 Booth sequencer.
module mul_pair_engine #(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam int KW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_STORE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [KW-1:0]   k_q, k_d;
    logic [1:0]      byte_q, byte_d;
    logic [3:0]      iter_q, iter_d;
    logic [7:0]      a_hi_q, a_hi_d;
    logic [7:0]      a_lo_q, a_lo_d;
    logic [7:0]      b_hi_q, b_hi_d;
    logic [16:0]     acc_q, acc_d;
    logic [15:0]     q_q, q_d;
    logic            qm1_q, qm1_d;

    logic [16:0]     a_ext;
    logic [16:0]     booth_sum;
    logic [31:0]     product;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            k_q     <= '0;
            byte_q  <= '0;
            iter_q  <= '0;
            a_hi_q  <= '0;
            a_lo_q  <= '0;
            b_hi_q  <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            k_q     <= k_d;
            byte_q  <= byte_d;
            iter_q  <= iter_d;
            a_hi_q  <= a_hi_d;
            a_lo_q  <= a_lo_d;
            b_hi_q  <= b_hi_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
        end
    end

    // 17-bit accumulator keeps -32768 * -32768 from overflowing mid-sequence.
    always_comb begin
        a_ext = {a_hi_q[7], a_hi_q, a_lo_q};
        unique case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + a_ext;
            2'b10:   booth_sum = acc_q - a_ext;
            default: booth_sum = acc_q;
        endcase
        product = {acc_q[15:0], q_q};
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        k_d     = k_q;
        byte_d  = byte_q;
        iter_d  = iter_q;
        a_hi_d  = a_hi_q;
        a_lo_d  = a_lo_q;
        b_hi_d  = b_hi_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    k_d     = '0;
                    byte_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                byte_d = byte_q + 2'd1;
                unique case (byte_q)
                    2'd0: a_hi_d = mem_rd_data;
                    2'd1: a_lo_d = mem_rd_data;
                    2'd2: b_hi_d = mem_rd_data;
                    default: begin
                        // B_lo lands directly in the low byte of Q.
                        q_d     = {b_hi_q, mem_rd_data};
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        iter_d  = '0;
                        state_d = S_MULT;
                    end
                endcase
            end
            S_MULT: begin
                acc_d  = {booth_sum[16], booth_sum[16:1]};
                q_d    = {booth_sum[0], q_q[15:1]};
                qm1_d  = q_q[0];
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    byte_d  = '0;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                byte_d = byte_q + 2'd1;
                if (byte_q == 2'd3) begin
                    if (k_q == KW'(NUM_PAIRS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    armed_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done        = (state_q == S_DONE);
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        unique case (state_q)
            S_LOAD: mem_addr = AW'(SRC_BASE) + AW'({k_q, byte_q});
            S_STORE: begin
                mem_wr_en = 1'b1;
                mem_addr  = AW'(DST_BASE) + AW'({k_q, byte_q});
                unique case (byte_q)
                    2'd0:    mem_wr_data = product[31:24];
                    2'd1:    mem_wr_data = product[23:16];
                    2'd2:    mem_wr_data = product[15:8];
                    default: mem_wr_data = product[7:0];
                endcase
            end
            default: ;
        endcase
    end

endmodule
